// File: rtl/accum_fixed_int16.sv
// accum_fixed_int16
// -----------------------------------------------------------------------------
// Frame accumulator for sign-magnitude samples with per-step saturation.
//
// Samples stream in over a valid/ready handshake. Each accepted sample is added
// to a running sign-magnitude sum that clamps to +/-(2^(WIDTH-1)-1) on every
// step. A saturation flag and a sample count (sticky at 255) are kept alongside
// the sum. The sample flagged with in_last closes the frame. The totals,
// including that sample, are then held on the output handshake until downstream
// takes them. After that the block clears its running state and accepts the
// next frame.
//
// Ports
//   CLK        system clock, rising edge
//   RST        synchronous active-high reset
//   in_valid   upstream sample valid
//   in_ready   block accepts a sample this cycle (high while accumulating)
//   in_data    sign-magnitude sample, MSB is the sign
//   in_last    final sample of the frame, qualified by in_valid
//   out_valid  frame result is presented
//   out_ready  downstream accepts the frame result
//   out_data   saturated sign-magnitude frame sum
//   out_sat    saturation occurred at least once in the frame
//   out_count  samples in the frame, saturating at 255
// -----------------------------------------------------------------------------
module accum_fixed_int16 #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sat,
    output logic [7:0]       out_count
);

    localparam int              MAG_W   = WIDTH - 1;
    localparam logic [MAG_W-1:0] MAG_MAX = '1;
    localparam logic [7:0]      CNT_MAX = 8'hFF;

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Running frame state
    logic [WIDTH-1:0] acc_reg;
    logic [7:0]       count_reg;
    logic             sat_reg;

    // Held frame result
    logic [WIDTH-1:0] out_data_reg;
    logic             out_sat_reg;
    logic [7:0]       out_count_reg;

    // Handshake qualifiers
    logic accept;
    logic take;

    // -------------------------------------------------------------------------
    // Sign-magnitude adder with clamp
    // -------------------------------------------------------------------------
    logic             acc_sign;
    logic [MAG_W-1:0] acc_mag;
    logic             smp_sign;
    logic [MAG_W-1:0] smp_mag;
    logic [MAG_W:0]   mag_sum;
    logic             acc_ge_smp;

    logic             sum_sign;
    logic [MAG_W-1:0] sum_mag;
    logic             step_ovf;
    logic [WIDTH-1:0] sum_word;
    logic [7:0]       count_inc;

    assign acc_sign   = acc_reg[WIDTH-1];
    assign acc_mag    = acc_reg[MAG_W-1:0];
    assign smp_mag    = in_data[MAG_W-1:0];
    // A negative zero sample is folded to positive zero up front. The
    // same-sign/differing-sign decision below then never sees a signed zero.
    assign smp_sign   = in_data[WIDTH-1] & (smp_mag != '0);
    assign mag_sum    = {1'b0, acc_mag} + {1'b0, smp_mag};
    assign acc_ge_smp = (acc_mag >= smp_mag);

    always_comb begin
        sum_sign = 1'b0;
        sum_mag  = '0;
        step_ovf = 1'b0;

        if (acc_sign == smp_sign) begin
            // The magnitude limit is all ones, so a carry out of the
            // magnitude field is exactly the "exceeds limit" condition.
            sum_sign = acc_sign;
            if (mag_sum[MAG_W]) begin
                sum_mag  = MAG_MAX;
                step_ovf = 1'b1;
            end else begin
                sum_mag = mag_sum[MAG_W-1:0];
            end
        end else if (acc_ge_smp) begin
            sum_sign = acc_sign;
            sum_mag  = acc_mag - smp_mag;
        end else begin
            sum_sign = smp_sign;
            sum_mag  = smp_mag - acc_mag;
        end

        // Cancellation can leave a signed zero. Always store it as +0.
        if (sum_mag == '0) begin
            sum_sign = 1'b0;
        end
    end

    assign sum_word  = {sum_sign, sum_mag};
    assign count_inc = (count_reg == CNT_MAX) ? count_reg : count_reg + 8'd1;

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= ST_ACCUM;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;

        case (state_reg)
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ST_ACCUM;
                end
            end
            default: begin
                state_next = ST_ACCUM;
            end
        endcase
    end

    assign accept = in_valid & in_ready;
    assign take   = out_valid & out_ready;

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            acc_reg       <= '0;
            count_reg     <= '0;
            sat_reg       <= 1'b0;
            out_data_reg  <= '0;
            out_sat_reg   <= 1'b0;
            out_count_reg <= '0;
        end else begin
            if (accept) begin
                acc_reg   <= sum_word;
                count_reg <= count_inc;
                sat_reg   <= sat_reg | step_ovf;
                // The result registers are loaded only when a frame closes.
                // They are not written again while the result is held.
                if (in_last) begin
                    out_data_reg  <= sum_word;
                    out_sat_reg   <= sat_reg | step_ovf;
                    out_count_reg <= count_inc;
                end
            end
            // accept and take are mutually exclusive because they belong to
            // different states. The clear therefore never races a sample update.
            if (take) begin
                acc_reg   <= '0;
                count_reg <= '0;
                sat_reg   <= 1'b0;
            end
        end
    end

    assign out_data  = out_data_reg;
    assign out_sat   = out_sat_reg;
    assign out_count = out_count_reg;

endmodule

// File: tb/tb_accum_fixed_int16.sv
// tb_accum_fixed_int16
// -----------------------------------------------------------------------------
// Self-checking bench for accum_fixed_int16. Frames are played from a queue.
// The expected totals come from an integer-arithmetic model: samples are
// converted to signed integers, summed with a clamp to +/-32767, and the
// result is converted back to sign-magnitude. The bench prints one line per
// frame.
// -----------------------------------------------------------------------------
module tb_accum_fixed_int16;

    logic        CLK;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_sat;
    logic [7:0]  out_count;

    int n_checks = 0;
    int n_bad    = 0;

    logic [15:0] frame_q[$];

    accum_fixed_int16 #(.WIDTH(16)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_count (out_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Converts a sign-magnitude word to an integer. -0 becomes 0 naturally.
    function automatic int sm_to_int(input logic [15:0] w);
        int m;
        m = int'(w[14:0]);
        return w[15] ? -m : m;
    endfunction

    function automatic logic [15:0] int_to_sm(input int v);
        logic [15:0] w;
        if (v < 0) begin
            w = 16'(-v);
            w[15] = 1'b1;
        end else begin
            w = 16'(v);
        end
        return w;
    endfunction

    // Computes the expected frame totals from frame_q.
    task automatic model_frame(output logic [15:0] exp_data, output bit exp_sat, output int exp_cnt);
        int acc;
        acc = 0;
        exp_sat = 1'b0;
        exp_cnt = 0;
        foreach (frame_q[i]) begin
            acc = acc + sm_to_int(frame_q[i]);
            if (acc > 32767) begin
                acc = 32767;
                exp_sat = 1'b1;
            end else if (acc < -32767) begin
                acc = -32767;
                exp_sat = 1'b1;
            end
            if (exp_cnt < 255) exp_cnt++;
        end
        exp_data = int_to_sm(acc);
    endtask

    // Plays frame_q, then holds out_ready low for hold cycles while offering
    // junk samples. Finally it completes the transfer.
    task automatic run_frame(input string name, input int hold, input bit gaps);
        logic [15:0] exp_data;
        bit          exp_sat;
        int          exp_cnt;
        int          n;
        model_frame(exp_data, exp_sat, exp_cnt);
        n = frame_q.size();
        for (int i = 0; i < n; i++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                @(negedge CLK);
                in_valid  = 1'b0;
                in_data   = 16'($urandom);
                in_last   = 1'($urandom);
                out_ready = 1'($urandom);
            end
            @(negedge CLK);
            check_eq({name, " in_ready"}, 32'(in_ready), 32'd1);
            in_valid  = 1'b1;
            in_data   = frame_q[i];
            in_last   = (i == n - 1);
            out_ready = 1'($urandom);
        end
        for (int h = 0; h <= hold; h++) begin
            @(negedge CLK);
            check_eq({name, " out_valid"}, 32'(out_valid), 32'd1);
            check_eq({name, " hold_ready"}, 32'(in_ready), 32'd0);
            check_eq({name, " out_data"}, 32'(out_data), 32'(exp_data));
            check_eq({name, " out_sat"}, 32'(out_sat), 32'(exp_sat));
            check_eq({name, " out_count"}, 32'(out_count), 32'(exp_cnt));
            in_valid  = 1'($urandom);
            in_data   = 16'($urandom);
            in_last   = 1'($urandom);
            out_ready = (h == hold);
        end
        @(negedge CLK);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_eq({name, " post_valid"}, 32'(out_valid), 32'd0);
        check_eq({name, " post_ready"}, 32'(in_ready), 32'd1);
        $display("frame %s: n=%0d data=%h sat=%0d count=%0d exp=%h/%0d/%0d",
                 name, n, out_data, out_sat, out_count, exp_data, exp_sat, exp_cnt);
        frame_q.delete();
    endtask

    function automatic logic [15:0] rand_sample();
        logic [15:0] w;
        case ($urandom_range(0, 4))
            0:       w = 16'h8000;
            1:       w = {1'($urandom), 1'b1, 14'($urandom)};
            2:       w = {1'($urandom), 8'h00, 7'($urandom)};
            default: w = 16'($urandom);
        endcase
        return w;
    endfunction

    initial begin
        RST = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_eq("rst out_valid", 32'(out_valid), 32'd0);
        check_eq("rst out_data", 32'(out_data), 32'd0);
        check_eq("rst out_sat", 32'(out_sat), 32'd0);
        check_eq("rst out_count", 32'(out_count), 32'd0);
        check_eq("rst in_ready", 32'(in_ready), 32'd1);
        RST = 1'b0;

        frame_q = '{16'h4000, 16'h4000};           run_frame("pos_sat", 0, 0);
        frame_q = '{16'hC000, 16'hC000};           run_frame("neg_sat", 1, 0);
        frame_q = '{16'hC000, 16'h2000};           run_frame("mixed", 0, 0);
        frame_q = '{16'h0001, 16'h0001};           run_frame("small", 0, 0);
        frame_q = '{16'h4000, 16'h4000, 16'hA000}; run_frame("clamp_sub", 0, 0);
        frame_q = '{16'h8000};                     run_frame("neg_zero", 0, 0);
        frame_q = '{16'h0123};                     run_frame("single", 0, 0);
        frame_q = '{16'h1234, 16'h9234};           run_frame("cancel", 0, 0);
        frame_q = '{16'h0010, 16'h0020, 16'h0030}; run_frame("backpressure", 5, 0);

        // Reset mid-frame. The reset cycle also offers a last sample that must be dropped.
        @(negedge CLK); in_valid = 1'b1; in_data = 16'h1234; in_last = 1'b0;
        @(negedge CLK); in_data = 16'h0100;
        @(negedge CLK); RST = 1'b1; in_data = 16'h7000; in_last = 1'b1;
        @(negedge CLK); RST = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        check_eq("midrst out_valid", 32'(out_valid), 32'd0);
        check_eq("midrst in_ready", 32'(in_ready), 32'd1);
        frame_q = '{16'h0003};                     run_frame("after_rst", 0, 0);

        // Reset while a result is held. Reset takes priority over the transfer.
        @(negedge CLK); in_valid = 1'b1; in_data = 16'h0005; in_last = 1'b1;
        @(negedge CLK); in_valid = 1'b0; in_last = 1'b0;
        check_eq("holdrst pre_valid", 32'(out_valid), 32'd1);
        RST = 1'b1; out_ready = 1'b1;
        @(negedge CLK); RST = 1'b0; out_ready = 1'b0;
        check_eq("holdrst out_valid", 32'(out_valid), 32'd0);
        check_eq("holdrst out_data", 32'(out_data), 32'd0);
        check_eq("holdrst out_count", 32'(out_count), 32'd0);
        check_eq("holdrst in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 300; i++) frame_q.push_back(16'h0000);
        run_frame("zeros300", 0, 0);
        for (int i = 0; i < 270; i++) frame_q.push_back(16'h0001);
        run_frame("ones270", 1, 1);

        for (int f = 0; f < 25; f++) begin
            int len;
            len = $urandom_range(1, 10);
            for (int i = 0; i < len; i++) frame_q.push_back(rand_sample());
            run_frame($sformatf("rand%0d", f), $urandom_range(0, 4), 1);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/accum_fixed_int16.md
ACCUM_FIXED_INT16 -- requirements
Module: accum_fixed_int16

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the data word width in bits (sign-magnitude: MSB sign, WIDTH-1 magnitude bits).
REQ-002 The block SHALL have port CLK  input  1  single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid  input  1  upstream sample valid.
REQ-005 The block SHALL have port in_ready  output  1  block can accept a sample this cycle.
REQ-006 The block SHALL have port in_data  input  WIDTH  sign-magnitude sample.
REQ-007 The block SHALL have port in_last  input  1  marks the final sample of a frame; qualified by in_valid.
REQ-008 The block SHALL have port out_valid  output  1  frame sum is presented.
REQ-009 The block SHALL have port out_ready  input  1  downstream accepts the frame sum.
REQ-010 The block SHALL have port out_data  output  WIDTH  saturated sign-magnitude frame sum.
REQ-011 The block SHALL have port out_sat  output  1  saturation occurred at least once in the frame.
REQ-012 The block SHALL have port out_count  output  8  number of samples in the frame, saturating at 255.

Function
REQ-013 Sample transfer SHALL occur only on a cycle with in_valid=1 and in_ready=1; result transfer only on out_valid=1 and out_ready=1.
REQ-014 The block SHALL implement two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-015 In ACCUM, each accepted sample SHALL update acc <= sat_add(acc, in_data), count <= min(count+1, 255), sat <= sat | overflow.
REQ-016 sat_add SHALL be sign-magnitude addition: same signs add magnitudes; differing signs subtract smaller magnitude from larger and take the sign of the larger.
REQ-017 When the magnitude sum exceeds 2^(WIDTH-1)-1, sat_add SHALL return magnitude 0x7FFF with the operands' sign and assert overflow for that step.
REQ-018 Negative zero (0x8000) on in_data SHALL be treated as zero; any zero result SHALL be stored as 0x0000, never 0x8000.
REQ-019 Accepting a sample with in_last=1 SHALL load out_data/out_sat/out_count with the values including that sample and move to HOLD; out_valid SHALL rise the next cycle (1-cycle latency).
REQ-020 In HOLD, out_data, out_sat and out_count SHALL remain stable until the transfer completes, regardless of in_valid.
REQ-021 On the HOLD transfer cycle, the block SHALL clear acc, count and sat to 0 and return to ACCUM; in_ready SHALL be 1 the following cycle.
REQ-022 A single-sample frame (in_last on the first sample) SHALL produce out_data equal to the normalized sample and out_count=1.
REQ-023 Saturation SHALL be applied per step, so a later opposite-sign sample SHALL subtract from the clamped value 0x7FFF/0xFFFF.
REQ-024 The count SHALL stop at 255 while accumulation continues without limit on frame length.

Reset
REQ-025 With RST=1 at a rising edge, the block SHALL enter ACCUM and clear acc, count and sat; out_valid=0, out_data=0x0000, out_sat=0, out_count=0; in_ready=1 from the first cycle after reset.
REQ-026 RST SHALL take priority over any simultaneous transfer and SHALL discard a partial frame or a held result.

Verification
REQ-027 Frame {0x4000, 0x4000(last)} -> out_data=0x7FFF, out_sat=1, out_count=2.
REQ-028 Frame {0xC000, 0xC000(last)} -> 0xFFFF, sat=1; frame {0xC000, 0x2000(last)} -> 0xA000, sat=0; frame {0x0001, 0x0001(last)} -> 0x0002.
REQ-029 Frame {0x4000, 0x4000, 0xA000(last)} -> 0x5FFF, sat=1, count=3 (confirms per-step clamp); frame {0x8000(last)} -> 0x0000, count=1.
REQ-030 Backpressure: hold out_ready=0 for 5 cycles in HOLD while in_valid=1 -> in_ready=0, outputs stable, no sample lost; next frame begins only after the transfer.
REQ-031 Assert RST mid-frame after 2 samples, then send {0x0003(last)} -> out_data=0x0003, count=1, sat=0.
REQ-032 A 300-sample frame of 0x0000 -> out_data=0x0000, out_count=255, out_sat=0.
